// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package seq_shift_add_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // The iteration counter never needs to go below one bit, even at WIDTH=2.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_shift_add_mult_rca_add.sv
// Ripple-carry adder: a half adder at bit 0 (no carry-in), full adders above it.
module rca_add
    import seq_shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH-1:0] c;

    assign s[0] = x[0] ^ y[0];
    assign c[0] = x[0] & y[0];

    for (genvar i = 1; i < WIDTH; i++) begin : g_fa
        assign s[i] = x[i] ^ y[i] ^ c[i-1];
        assign c[i] = (x[i] & y[i]) | (c[i-1] & (x[i] ^ y[i]));
    end

    assign cout = c[WIDTH-1];

endmodule

// File: rtl/seq_shift_add_mult.sv
// Radix-2 shift-add unsigned multiplier, one partial product per clock through rca_add.
//   state | meaning
//   IDLE  | in_ready high, waiting for an operand pair
//   RUN   | WIDTH add/shift iterations, one per cycle
//   DONE  | product held on p with out_valid high until out_ready
module seq_shift_add_mult
    import seq_shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int PW = prod_width(WIDTH),
    localparam int CW = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    p
);

    state_t           state, state_next;
    logic [WIDTH-1:0] mcand, hi, lo;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] addend, sum_s;
    logic             sum_c;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic             last_iter;

    assign addend    = lo[0] ? mcand : '0;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    rca_add #(.WIDTH(WIDTH)) u_add (
        .x    (hi),
        .y    (addend),
        .s    (sum_s),
        .cout (sum_c)
    );

    // The adder carry becomes the top bit of the shifted high half, so nothing is lost.
    assign hi_next = {sum_c, sum_s[WIDTH-1:1]};
    assign lo_next = {sum_s[0], lo[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= a;
                        lo    <= b;
                        hi    <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    hi  <= hi_next;
                    lo  <= lo_next;
                    cnt <= cnt + 1'b1;
                    if (last_iter) p <= {hi_next, lo_next};
                end
                default: ;
            endcase
        end
    end

endmodule
